// File: rtl/draw_compositor_if.sv
// Pixel-side bundle between the sprite draw objects, the compositor and the
// VGA/game-logic consumers. The source side drives object flags and colours;
// the compositor drives the composited pixel and the collision report.
interface draw_compositor_if #(
    parameter int NUM_OBJ = 4
);
    localparam int NUM_PAIRS = NUM_OBJ * (NUM_OBJ - 1) / 2;

    logic                   startOfFrame;
    logic                   display_en;
    logic [NUM_OBJ-1:0]     obj_drawing;
    logic [12*NUM_OBJ-1:0]  obj_rgb;
    logic [11:0]            bg_rgb;

    logic [3:0]             Red_level;
    logic [3:0]             Green_level;
    logic [3:0]             Blue_level;
    logic [NUM_PAIRS-1:0]   collision_map;
    logic [15:0]            collision_count;
    logic                   collision_valid;

    modport master (
        output startOfFrame, display_en, obj_drawing, obj_rgb, bg_rgb,
        input  Red_level, Green_level, Blue_level,
        input  collision_map, collision_count, collision_valid
    );

    modport slave (
        input  startOfFrame, display_en, obj_drawing, obj_rgb, bg_rgb,
        output Red_level, Green_level, Blue_level,
        output collision_map, collision_count, collision_valid
    );
endinterface

// File: rtl/draw_compositor.sv
// Priority compositor for NUM_OBJ sprite objects with per-frame collision
// accumulation. Lowest object index wins the pixel; background shows when no
// object draws. Pairwise collisions are OR-accumulated over a frame and the
// totals are published on the next startOfFrame.
module draw_compositor #(
    parameter int NUM_OBJ = 4
) (
    input  logic              clk,
    input  logic              reset,
    draw_compositor_if.slave  bus
);
    localparam int NUM_PAIRS = NUM_OBJ * (NUM_OBJ - 1) / 2;

    typedef enum logic {IDLE, RUN} state_t;

    // Saturating increment: the pixel counter sticks at all-ones, never wraps.
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
        if (inc && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end
        return v;
    endfunction

    state_t                 state_q, state_d;
    logic [NUM_PAIRS-1:0]   acc_map_q, acc_map_d;
    logic [15:0]            acc_cnt_q, acc_cnt_d;
    logic [NUM_PAIRS-1:0]   map_q, map_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   vld_q, vld_d;
    logic [11:0]            rgb_q, rgb_d;

    logic [NUM_PAIRS-1:0]   pair_hit;
    logic                   colliding;

    // Pair (i,j), i<j, maps to lexicographic index i*N - i*(i+1)/2 + (j-i-1).
    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_row
        for (genvar gj = gi + 1; gj < NUM_OBJ; gj++) begin : g_col
            localparam int IDX = gi * NUM_OBJ - (gi * (gi + 1)) / 2 + (gj - gi - 1);
            assign pair_hit[IDX] = bus.display_en & bus.obj_drawing[gi] & bus.obj_drawing[gj];
        end
    end

    // Any set pair bit implies at least two objects drawing in active video.
    assign colliding = |pair_hit;

    // Colour select: scan from the highest index down so the lowest drawing object wins.
    always_comb begin
        rgb_d = bus.bg_rgb;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (bus.obj_drawing[i]) begin
                rgb_d = bus.obj_rgb[12*i +: 12];
            end
        end
        if (!bus.display_en) begin
            rgb_d = 12'h000;
        end
    end

    // Next-state and accumulator/publish logic for the frame FSM.
    always_comb begin
        state_d   = state_q;
        acc_map_d = acc_map_q;
        acc_cnt_d = acc_cnt_q;
        map_d     = map_q;
        cnt_d     = cnt_q;
        vld_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // No frame has started yet, so there is nothing to publish.
                acc_map_d = '0;
                acc_cnt_d = '0;
                if (bus.startOfFrame) begin
                    state_d   = RUN;
                    acc_map_d = pair_hit;
                    acc_cnt_d = {15'd0, colliding};
                end
            end
            RUN: begin
                if (bus.startOfFrame) begin
                    // Publish only what earlier cycles gathered; this pixel seeds the new frame.
                    map_d     = acc_map_q;
                    cnt_d     = acc_cnt_q;
                    vld_d     = 1'b1;
                    acc_map_d = pair_hit;
                    acc_cnt_d = {15'd0, colliding};
                end else begin
                    acc_map_d = acc_map_q | pair_hit;
                    acc_cnt_d = sat_inc(acc_cnt_q, colliding);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame state, accumulators and published collision report.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_map_q <= '0;
            acc_cnt_q <= '0;
            map_q     <= '0;
            cnt_q     <= '0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_map_q <= acc_map_d;
            acc_cnt_q <= acc_cnt_d;
            map_q     <= map_d;
            cnt_q     <= cnt_d;
            vld_q     <= vld_d;
        end
    end

    // Composited pixel register, one pixel per clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= 12'h000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign bus.Red_level       = rgb_q[11:8];
    assign bus.Green_level     = rgb_q[7:4];
    assign bus.Blue_level      = rgb_q[3:0];
    assign bus.collision_map   = map_q;
    assign bus.collision_count = cnt_q;
    assign bus.collision_valid = vld_q;
endmodule

// File: tb/tb_draw_compositor.sv
// Testbench for draw_compositor: directed table, directed frame sequences and
// randomized traffic against a frame-level reference model.
module tb_draw_compositor;
    localparam int N  = 4;
    localparam int NP = N * (N - 1) / 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    draw_compositor_if #(.NUM_OBJ(N)) bus ();
    draw_compositor #(.NUM_OBJ(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: expected outputs and the frame being gathered.
    logic [11:0]   e_rgb;
    logic [NP-1:0] e_map;
    logic [15:0]   e_cnt;
    logic          e_vld;
    bit            running;
    logic [NP-1:0] m_map;
    int            m_cnt;

    typedef struct {
        bit             de;
        logic [N-1:0]   d;
        logic [12*N-1:0] orgb;
        logic [11:0]    bg;
        logic [11:0]    exp_rgb;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one pixel, advance the model by one clock, and optionally compare.
    task automatic step(input bit rst, input bit sof, input bit de, input logic [N-1:0] d,
                        input logic [12*N-1:0] orgb, input logic [11:0] bg, input bit chk);
        logic [NP-1:0] pb;
        int            k;
        bit            coll;
        bit            found;
        reset            = rst;
        bus.startOfFrame = sof;
        bus.display_en   = de;
        bus.obj_drawing  = d;
        bus.obj_rgb      = orgb;
        bus.bg_rgb       = bg;

        pb = '0;
        k  = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                if (de && d[i] && d[j]) pb[k] = 1'b1;
                k++;
            end
        end
        coll = de && ($countones(d) >= 2);

        if (rst) begin
            e_rgb = 12'h000; e_map = '0; e_cnt = '0; e_vld = 1'b0;
            running = 1'b0; m_map = '0; m_cnt = 0;
        end else begin
            found = 1'b0;
            e_rgb = bg;
            for (int i = 0; i < N; i++) begin
                if (!found && d[i]) begin
                    e_rgb = orgb[12*i +: 12];
                    found = 1'b1;
                end
            end
            if (!de) e_rgb = 12'h000;
            e_vld = 1'b0;
            if (sof) begin
                if (running) begin
                    e_map = m_map;
                    e_cnt = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
                    e_vld = 1'b1;
                end
                running = 1'b1;
                m_map = pb;
                m_cnt = coll ? 1 : 0;
            end else if (running) begin
                m_map |= pb;
                m_cnt += coll ? 1 : 0;
            end
        end

        @(posedge clk);
        #1;
        if (chk) begin
            check("rgb", {bus.Red_level, bus.Green_level, bus.Blue_level}, e_rgb);
            check("map", bus.collision_map, e_map);
            check("cnt", bus.collision_count, e_cnt);
            check("vld", bus.collision_valid, e_vld);
        end
    endtask

    function automatic logic [11:0] out_rgb();
        return {bus.Red_level, bus.Green_level, bus.Blue_level};
    endfunction

    vec_t vecs[5];
    logic [12*N-1:0] zrgb;

    initial begin
        zrgb = '0;
        vecs[0] = '{1'b1, 4'b1010, {12'h456, 12'h000, 12'h123, 12'h000}, 12'h0F0, 12'h123};
        vecs[1] = '{1'b1, 4'b0000, {12'h456, 12'h000, 12'h123, 12'h000}, 12'h0F0, 12'h0F0};
        vecs[2] = '{1'b0, 4'b1010, {12'h456, 12'h000, 12'h123, 12'h000}, 12'h0F0, 12'h000};
        vecs[3] = '{1'b1, 4'b1111, {12'hABC, 12'hDEF, 12'h111, 12'h222}, 12'h0F0, 12'h222};
        vecs[4] = '{1'b1, 4'b1100, {12'hABC, 12'hDEF, 12'h111, 12'h222}, 12'h0F0, 12'hDEF};

        // Reset held two cycles with everything drawing 0xABC and a SOF.
        step(1, 1, 1, 4'b1111, {4{12'hABC}}, 12'hABC, 1);
        step(1, 1, 1, 4'b1111, {4{12'hABC}}, 12'hABC, 1);
        check("reset_rgb", out_rgb(), 12'h000);
        check("reset_vld", bus.collision_valid, 1'b0);

        // Priority table.
        for (int v = 0; v < 5; v++) begin
            step(0, 0, vecs[v].de, vecs[v].d, vecs[v].orgb, vecs[v].bg, 1);
            check($sformatf("prio_%0d", v), out_rgb(), vecs[v].exp_rgb);
        end

        // Collision frame: first SOF after reset gives no pulse.
        step(1, 0, 0, 4'b0000, zrgb, 12'h000, 1);
        step(0, 1, 1, 4'b0000, zrgb, 12'h000, 1);
        check("first_sof_vld", bus.collision_valid, 1'b0);
        for (int p = 0; p < 10; p++) step(0, 0, 1, 4'b0101, zrgb, 12'h000, 1);
        for (int p = 0; p < 5; p++)  step(0, 0, 1, 4'b1110, zrgb, 12'h000, 1);
        step(0, 1, 1, 4'b0000, zrgb, 12'h000, 1);
        check("frame_map", bus.collision_map, 6'b111010);
        check("frame_cnt", bus.collision_count, 16'd15);
        check("frame_vld", bus.collision_valid, 1'b1);

        // Blanking: collisions outside active video do not count.
        for (int p = 0; p < 6; p++) step(0, 0, 0, 4'b0011, zrgb, 12'h000, 1);
        check("pulse_one_cycle", bus.collision_valid, 1'b0);
        step(0, 1, 1, 4'b0000, zrgb, 12'h000, 1);
        check("blank_map", bus.collision_map, 6'b000000);
        check("blank_cnt", bus.collision_count, 16'd0);
        check("blank_vld", bus.collision_valid, 1'b1);

        // Back-to-back SOF: second publish reflects the single pixel between.
        step(0, 0, 1, 4'b1001, zrgb, 12'h000, 1);
        step(0, 1, 1, 4'b0000, zrgb, 12'h000, 1);
        step(0, 1, 1, 4'b0000, zrgb, 12'h000, 1);
        check("b2b_map", bus.collision_map, 6'b000000);
        check("b2b_vld", bus.collision_valid, 1'b1);

        // Reset mid-frame discards the partial frame.
        step(0, 1, 1, 4'b1111, zrgb, 12'h000, 1);
        for (int p = 0; p < 8; p++) step(0, 0, 1, 4'b1111, zrgb, 12'h000, 1);
        step(1, 0, 1, 4'b1111, zrgb, 12'h000, 1);
        check("midrst_vld0", bus.collision_valid, 1'b0);
        step(0, 1, 1, 4'b0000, zrgb, 12'h000, 1);
        check("midrst_vld1", bus.collision_valid, 1'b0);
        for (int p = 0; p < 3; p++) step(0, 0, 1, 4'b0011, zrgb, 12'h000, 1);
        step(0, 1, 1, 4'b0000, zrgb, 12'h000, 1);
        check("midrst_map", bus.collision_map, 6'b000001);
        check("midrst_cnt", bus.collision_count, 16'd3);
        check("midrst_vld2", bus.collision_valid, 1'b1);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), 4'($urandom),
                 {12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)},
                 12'($urandom), 1);
        end

        // Saturation: 70000 colliding pixels in one frame.
        step(0, 1, 1, 4'b0000, zrgb, 12'h000, 1);
        for (int p = 0; p < 70000; p++) step(0, 0, 1, 4'b1111, zrgb, 12'h000, 0);
        step(0, 1, 1, 4'b0000, zrgb, 12'h000, 1);
        check("sat_cnt", bus.collision_count, 16'hFFFF);
        check("sat_map", bus.collision_map, 6'b111111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/draw_compositor.md
# draw_compositor

Pixel-level compositor that consumes the per-object `Drawing` flag and 4-bit RGB levels produced by the sprite draw objects, and emits one registered RGB pixel to the VGA output stage. Lower object index wins priority; when no object draws, a background colour is shown. It also accumulates pairwise object collisions over each frame and publishes them at frame start, for the game logic.

## Interface
- `NUM_OBJ`, 4: number of draw objects (2..8).
- `NUM_PAIRS`, NUM_OBJ*(NUM_OBJ-1)/2: derived, not overridable.
- `clk`  in  1  pixel clock.
- `reset`  in  1  synchronous, active-high reset.
- `startOfFrame`  in  1  one-cycle pulse, first pixel of a frame.
- `display_en`  in  1  1 = active video area.
- `obj_drawing`  in  NUM_OBJ  bit i = object i `Drawing`.
- `obj_rgb`  in  12*NUM_OBJ  object i colour at bits [12i+11:12i], {R,G,B} 4 bits each.
- `bg_rgb`  in  12  background colour {R,G,B}.
- `Red_level`, `Green_level`, `Blue_level`  out  4 each  composited pixel.
- `collision_map`  out  NUM_PAIRS  per-pair collisions of the previous frame.
- `collision_count`  out  16  colliding pixels in previous frame, saturating.
- `collision_valid`  out  1  one-cycle pulse when `collision_map`/`collision_count` update.

## Operation
- Pair index: lexicographic over (i,j), i<j: (0,1)=0, (0,2)=1, …, (0,N-1), (1,2), …, (N-2,N-1). N=4: (0,1)0 (0,2)1 (0,3)2 (1,2)3 (1,3)4 (2,3)5.
- Colour select (registered): if `display_en`=0 -> 0x000; else lowest i with `obj_drawing[i]`=1 -> that object's RGB; else `bg_rgb`.
- Collision detect (combinational on current inputs, gated by `display_en`=1): pair bit set when both objects draw; pixel is colliding when ≥2 bits of `obj_drawing` are set.
- Accumulator `acc_map` (NUM_PAIRS, sticky OR) and `acc_cnt` (16 bit, +1 per colliding pixel, saturates at 0xFFFF, no wrap).
- State machine: IDLE, RUN.
  - IDLE (after reset): accumulators held at 0, outputs hold; on `startOfFrame` -> RUN, accumulators start with this cycle's pixel; no `collision_valid` (no full frame yet).
  - RUN: accumulate every cycle. On `startOfFrame`: `collision_map`<=`acc_map`, `collision_count`<=`acc_cnt` (values from previous cycles only), `collision_valid`<=1 next cycle, accumulators restart with the current pixel's contribution only. Stay RUN.
- `startOfFrame` with `display_en`=0: publish/restart still occur; current pixel contributes nothing.

## Timing
- Reset (synchronous, `reset`=1 at clk edge): `Red_level`/`Green_level`/`Blue_level`=0, `collision_map`=0, `collision_count`=0, `collision_valid`=0, accumulators=0, state=IDLE. Reset overrides all other inputs including `startOfFrame` in the same cycle.
- Reset mid-frame: accumulated data discarded, no publish; next `startOfFrame` is treated as first frame (no `collision_valid`).
- Colour latency: 1 cycle from inputs to RGB outputs; no stall, one pixel per clock.
- Publish latency: `collision_map`/`collision_count` change at the edge sampling `startOfFrame`; `collision_valid` high for exactly the following cycle, simultaneously visible with the new values.
- Back-to-back `startOfFrame` on consecutive cycles: each publishes; second publish reflects the single pixel in between.

## Test plan
- Reset: hold `reset` 2 cycles with all objects drawing 0xABC -> outputs all 0, no `collision_valid`.
- Priority: `display_en`=1, `obj_drawing`=4'b1010, obj1=0x123, obj3=0x456, bg=0x0F0 -> next cycle RGB=1,2,3; `obj_drawing`=0 -> 0,F,0; `display_en`=0 -> 0,0,0.
- Collision frame: SOF, then 10 pixels with obj0&obj2 drawing, 5 pixels with obj1&obj2&obj3, SOF -> `collision_map`=6'b111010 (pairs 1,3,4,5), `collision_count`=15, `collision_valid` one cycle; first SOF after reset gives no pulse.
- Blanking: frame with obj0&obj1 drawing only while `display_en`=0 -> next publish `collision_map`=0, count=0, pulse still asserted.
- Saturation: 70000 colliding pixels in one frame -> `collision_count`=0xFFFF.
- Reset mid-frame: SOF, 8 colliding pixels, `reset`, SOF, 3 colliding (0,1), SOF -> only last SOF pulses, map=6'b000001, count=3.
